ct_lsu_spsram_ctrl: RTL

Access controller for one 512x52 single-port SRAM macro in the LSU. It zero-fills the array after reset and then shares the single port between one write requester and one read requester with round-robin arbitration. It drives the macro's active-low controls (CEN, GWEN, bitwise WEN) and returns read data one cycle after grant.

---
 rtl/ct_lsu_spsram_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ct_lsu_spsram_ctrl.sv
// ct_lsu_spsram_ctrl
//   Access controller for one single-port SRAM macro (default 512x52) in the LSU.
//   After reset it can zero-fill the whole array. After that it shares the port
//   between one write requester and one read requester using round-robin
//   arbitration. Read data comes back one cycle after the read grant.
//
//   Optional feature macro: CT_SPSRAM_CTRL_INIT_EN
//     defined   : INIT state and init counter are built; the array is zeroed
//                 after every reset and init_done rises when the fill ends.
//     undefined : there is no INIT phase; init_done is tied high.
//
// Ports
//   forever_cpuclk, cpurst_b        clock (rising edge), async active-low reset
//   wr_req_vld/addr/data/bmask      write request; bmask is an active-high bit enable
//   wr_req_grnt                     write accepted this cycle
//   rd_req_vld/addr                 read request
//   rd_req_grnt                     read accepted this cycle
//   rd_data_vld, rd_data            read result, one cycle after rd_req_grnt
//   init_done                       array is initialised and grants are possible
//   sram_cen/gwen/wen/a/d, sram_q   macro interface; all controls are active-low
module ct_lsu_spsram_ctrl #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 52
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  wr_req_vld,
   input  logic [ADDR_WIDTH-1:0] wr_req_addr,
   input  logic [DATA_WIDTH-1:0] wr_req_data,
   input  logic [DATA_WIDTH-1:0] wr_req_bmask,
   output logic                  wr_req_grnt,
   input  logic                  rd_req_vld,
   input  logic [ADDR_WIDTH-1:0] rd_req_addr,
   output logic                  rd_req_grnt,
   output logic                  rd_data_vld,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  init_done,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   logic                  in_init;
   // Remembers which requester won the last grant. It resets to "read" so that
   // a write wins the first contended cycle.
   logic                  last_rd_q, last_rd_d;
   logic                  rd_data_vld_q, rd_data_vld_d;
   // sram_a/sram_d keep their last driven value while the port is idle.
   logic [ADDR_WIDTH-1:0] a_hold_q, a_hold_d;
   logic [DATA_WIDTH-1:0] d_hold_q, d_hold_d;

`ifdef CT_SPSRAM_CTRL_INIT_EN
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

   // state register
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      case (state_q)
         ST_INIT: begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == '1) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   assign in_init   = (state_q == ST_INIT);
   assign init_done = (state_q == ST_RUN);
`else
   assign in_init   = 1'b0;
   assign init_done = 1'b1;
`endif

   // output logic: grants and macro controls
   always_comb begin
      wr_req_grnt = 1'b0;
      rd_req_grnt = 1'b0;
      sram_cen    = 1'b1;
      sram_gwen   = 1'b1;
      sram_wen    = '1;
      sram_a      = a_hold_q;
      sram_d      = d_hold_q;
      if (in_init) begin
`ifdef CT_SPSRAM_CTRL_INIT_EN
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = '0;
         sram_a    = init_cnt_q;
         sram_d    = '0;
`endif
      end else begin
         wr_req_grnt = wr_req_vld & (~rd_req_vld | last_rd_q);
         rd_req_grnt = rd_req_vld & (~wr_req_vld | ~last_rd_q);
         if (wr_req_grnt) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~wr_req_bmask;
            sram_a    = wr_req_addr;
            sram_d    = wr_req_data;
         end else if (rd_req_grnt) begin
            sram_cen  = 1'b0;
            sram_a    = rd_req_addr;
         end
      end
   end

   always_comb begin
      last_rd_d     = (wr_req_grnt | rd_req_grnt) ? rd_req_grnt : last_rd_q;
      rd_data_vld_d = rd_req_grnt;
      a_hold_d      = sram_a;
      d_hold_d      = sram_d;
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         last_rd_q     <= 1'b1;
         rd_data_vld_q <= 1'b0;
         a_hold_q      <= '0;
         d_hold_q      <= '0;
      end else begin
         last_rd_q     <= last_rd_d;
         rd_data_vld_q <= rd_data_vld_d;
         a_hold_q      <= a_hold_d;
         d_hold_q      <= d_hold_d;
      end
   end

   assign rd_data_vld = rd_data_vld_q;
   assign rd_data     = sram_q;

endmodule
